iterative_alu: RTL and testbench
================================

Name: iterative_alu

Overview:
- Multi-cycle execute-stage ALU directly downstream of the ALU control decoder.
- Consumes the decoder's 4-bit alu_control code plus two operands and produces a registered result and a zero flag.
- Logic/arithmetic ops complete in one cycle; shifts iterate one bit per cycle to save area.
- Valid/ready handshake on both sides so the multicycle control FSM can stall on it.

Parameters:
WIDTH, 32, operand/result width; shift amount = b[$clog2(WIDTH)-1:0]

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous abort of any operation in flight
in_valid  input  1  operands and code valid
in_ready  output  1  block can accept an operation (high only in IDLE)
alu_control  input  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10-15 undefined
a  input  WIDTH  operand A (shift source)
b  input  WIDTH  operand B (shift amount in low bits)
out_valid  output  1  result valid, held until consumed
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  registered, 1 when result == 0

Behaviour:
- Interface: one clock (clk), reset asynchronous and active-high (reset).
- States: IDLE, SHIFT, DONE.
- Reset, asynchronous: state IDLE, in_ready=1, out_valid=0, result=0, zero=0, shift counter=0.
- Accept: in_valid && in_ready at a rising edge. Inputs are captured only then; ignored otherwise.
- IDLE, accept of a non-shift code, or a shift with shamt==0:
  - Compute, register result and zero, go to DONE.
  - out_valid is high the cycle after accept (latency 1).
  - A shamt==0 shift returns a unchanged.
- IDLE, accept of a shift with shamt>0: load accumulator=a, count=shamt, go to SHIFT.
- SHIFT, each cycle:
  - Shift accumulator 1 bit: SLL inserts 0 at LSB; SRL inserts 0 at MSB; SRA replicates MSB.
  - Decrement count. When count reaches 0, go to DONE with result=accumulator.
  - Total latency from accept to out_valid = shamt+1 cycles (max WIDTH).
- DONE:
  - out_valid=1; result and zero held stable.
  - If out_ready: go to IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
  - No same-cycle re-accept; minimum issue interval 2 cycles.
- Arithmetic:
  - ADD/SUB modulo 2^WIDTH, no flags beyond zero.
  - SLT compares signed, SLTU unsigned; result is 1 or 0, zero-extended.
  - XOR/OR/AND are bitwise.
- Undefined codes 10-15: result=0, zero=1, latency 1.
- zero is computed from the final result value in the same edge that loads result.
- flush:
  - Synchronous, priority over all non-reset actions.
  - Next state IDLE, out_valid=0, in_ready=1. result and zero keep their last values.
  - Flush coincident with an accept: the operation is dropped.
  - Flush in DONE discards the result even if out_ready is high.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values; no partial result visible.
- in_valid asserted while busy: ignored, no queueing; the producer must hold until in_ready.

Optional Feature:
- Macro: ITERATIVE_ALU_FAST_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter; every code has latency 1; SHIFT state and counter are not synthesized; in_ready behaviour is otherwise identical.
- Undefined: iterative shifting as above, shamt+1 cycle latency.

Test Plan:
- ADD a=32'h7FFF_FFFF, b=1 -> out_valid 1 cycle after accept, result=32'h8000_0000, zero=0. SUB a=5, b=5 -> result=0, zero=1.
- SLT a=32'hFFFF_FFFF, b=1 -> result=1. SLTU same operands -> result=0.
- SRA a=32'h8000_0000, b=31 (no fast macro) -> in_ready low 32 cycles, out_valid at cycle 32, result=32'hFFFF_FFFF. SRL same -> result=1. SLL a=1, b=0 -> result=1, latency 1.
- Backpressure: out_ready low 5 cycles in DONE -> out_valid and result stable, in_ready=0 throughout. A new in_valid pulse meanwhile is ignored.
- Flush at cycle 3 of SLL a=1, b=10 -> IDLE next cycle, out_valid never rises. The next ADD 2+3 -> result=5.
- Async reset asserted mid-SHIFT between clock edges -> in_ready=1, out_valid=0, result=0, zero=0 immediately. alu_control=4'hC -> result=0, zero=1. With ITERATIVE_ALU_FAST_SHIFT_EN, SRA case -> latency 1.

Source files
------------

// File: rtl/iterative_alu.sv
// iterative_alu -- multi-cycle execute-stage ALU.
//
// Takes the 4-bit alu_control code and two operands through a valid/ready
// handshake. It returns a registered result and zero flag through a
// valid/ready handshake.
//   - Logic and arithmetic ops finish in one cycle.
//   - Shifts move one bit per cycle, giving shamt+1 cycles of latency.
//
// Build option: define ITERATIVE_ALU_FAST_SHIFT_EN to use a combinational
// barrel shifter instead. Every code then has a latency of 1.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   flush        synchronous abort of any operation in flight
//   in_valid     operands and code valid
//   in_ready     can accept an operation (high only in IDLE)
//   alu_control  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA,
//                8 OR, 9 AND, 10-15 give result 0
//   a, b         operands; shift amount is the low $clog2(WIDTH) bits of b
//   out_valid    result valid, held until consumed
//   out_ready    consumer accepts result
//   result       registered result
//   zero         registered, 1 when result == 0
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// SHIFT | iterative shift in progress, one bit per cycle
// DONE  | result presented, waiting for out_ready

module iterative_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic             accept;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] comb_res;

    assign accept = in_valid && in_ready;
    assign shamt  = b[SW-1:0];

    // Single-cycle result. In the iterative build it also covers shifts by
    // zero, which simply pass a through.
    always_comb begin
        comb_res = '0;
        case (alu_control)
            OP_ADD:  comb_res = a + b;
            OP_SUB:  comb_res = a - b;
            OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  comb_res = a ^ b;
            OP_OR:   comb_res = a | b;
            OP_AND:  comb_res = a & b;
`ifdef ITERATIVE_ALU_FAST_SHIFT_EN
            OP_SLL:  comb_res = a << shamt;
            OP_SRL:  comb_res = a >> shamt;
            OP_SRA:  comb_res = $signed(a) >>> shamt;
`else
            OP_SLL:  comb_res = a;
            OP_SRL:  comb_res = a;
            OP_SRA:  comb_res = a;
`endif
            default: comb_res = '0;
        endcase
    end

`ifndef ITERATIVE_ALU_FAST_SHIFT_EN
    logic             is_shift;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SW-1:0]    cnt;
    logic [1:0]       shift_kind;    // 0 SLL, 1 SRL, 2 SRA

    assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                      (alu_control == OP_SRA);

    always_comb begin
        acc_next = acc;
        case (shift_kind)
            2'd0:    acc_next = {acc[WIDTH-2:0], 1'b0};
            2'd1:    acc_next = {1'b0, acc[WIDTH-1:1]};
            2'd2:    acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: acc_next = acc;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
`ifndef ITERATIVE_ALU_FAST_SHIFT_EN
            acc        <= '0;
            cnt        <= '0;
            shift_kind <= 2'd0;
`endif
        end else if (flush) begin
            // result and zero intentionally keep their last values
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifndef ITERATIVE_ALU_FAST_SHIFT_EN
                        if (is_shift && (shamt != '0)) begin
                            acc        <= a;
                            cnt        <= shamt;
                            shift_kind <= (alu_control == OP_SLL) ? 2'd0 :
                                          (alu_control == OP_SRL) ? 2'd1 : 2'd2;
                            state      <= SHIFT;
                            in_ready   <= 1'b0;
                        end else
`endif
                        begin
                            result    <= comb_res;
                            zero      <= (comb_res == '0);
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
`ifndef ITERATIVE_ALU_FAST_SHIFT_EN
                    acc <= acc_next;
                    cnt <= cnt - SW'(1);
                    // The last shift goes straight to DONE, so the total
                    // latency is shamt+1 cycles.
                    if (cnt == SW'(1)) begin
                        result    <= acc_next;
                        zero      <= (acc_next == '0);
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
`else
                    state    <= IDLE;
                    in_ready <= 1'b1;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
module tb_iterative_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_control = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;

    iterative_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .alu_control(alu_control),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] res;
        logic        z;
        int          lat;
        logic        is_shift;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input string n, input logic [3:0] op,
                                input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] res, input logic z,
                                input int lat, input logic sh);
        vec_t v;
        v.name = n; v.op = op; v.av = av; v.bv = bv;
        v.res = res; v.z = z; v.lat = lat; v.is_shift = sh;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Applies one operation, measures latency in cycles from the accept edge,
    // then checks the result and zero flag before consuming it.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er, input logic ez, input int el);
        int lat;
        wait_ready(name);
        alu_control = op; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        check({name, " latency"}, 32'(lat), 32'(el));
        check({name, " result"}, result, er);
        check({name, " zero"}, 32'(zero), 32'(ez));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin : main
        int exp_lat;
        int seen;
        logic [31:0] held;

        vecs[0]  = mk("add_ovf",   4'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 1,  1'b0);
        vecs[1]  = mk("sub_zero",  4'd1, 32'd5,         32'd5,         32'h0000_0000, 1'b1, 1,  1'b0);
        vecs[2]  = mk("slt_neg",   4'd3, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0, 1,  1'b0);
        vecs[3]  = mk("sltu_neg",  4'd4, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1, 1,  1'b0);
        vecs[4]  = mk("slt_pos",   4'd3, 32'd1,         32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1,  1'b0);
        vecs[5]  = mk("sltu_pos",  4'd4, 32'd1,         32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1,  1'b0);
        vecs[6]  = mk("xor",       4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1,  1'b0);
        vecs[7]  = mk("or",        4'd8, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1,  1'b0);
        vecs[8]  = mk("and",       4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1,  1'b0);
        vecs[9]  = mk("add_wrap",  4'd0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1, 1,  1'b0);
        vecs[10] = mk("sub_wrap",  4'd1, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1,  1'b0);
        vecs[11] = mk("sra_31",    4'd7, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 32, 1'b1);
        vecs[12] = mk("srl_31",    4'd6, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 32, 1'b1);
        vecs[13] = mk("sll_0",     4'd2, 32'd1,         32'd0,         32'h0000_0001, 1'b0, 1,  1'b0);
        vecs[14] = mk("sll_4",     4'd2, 32'd1,         32'd4,         32'h0000_0010, 1'b0, 5,  1'b1);
        vecs[15] = mk("sra_4",     4'd7, 32'h8000_00F0, 32'd4,         32'hF800_000F, 1'b0, 5,  1'b1);
        vecs[16] = mk("srl_hib",   4'd6, 32'hFFFF_FFFF, 32'h0000_0025, 32'h07FF_FFFF, 1'b0, 6,  1'b1);
        vecs[17] = mk("sll_out",   4'd2, 32'h8000_0001, 32'd1,         32'h0000_0002, 1'b0, 2,  1'b1);
        vecs[18] = mk("undef_c",   4'hC, 32'd7,         32'd9,         32'h0000_0000, 1'b1, 1,  1'b0);
        vecs[19] = mk("undef_f",   4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1,  1'b0);

        // Reset state
        #12;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", result, 32'd0);
        check("rst zero", 32'(zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            exp_lat = vecs[i].lat;
`ifdef ITERATIVE_ALU_FAST_SHIFT_EN
            if (vecs[i].is_shift) exp_lat = 1;
`endif
            run_op(vecs[i].name, vecs[i].op, vecs[i].av, vecs[i].bv,
                   vecs[i].res, vecs[i].z, exp_lat);
        end

        // Backpressure: result held while out_ready is low; a new request is ignored.
        wait_ready("bp");
        alu_control = 4'd0; a = 32'd2; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp result", result, 32'd5);
            check("bp in_ready", 32'(in_ready), 32'd0);
            if (c == 1) begin
                a = 32'd100; b = 32'd100; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp consumed out_valid", 32'(out_valid), 32'd0);
        check("bp consumed in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp no queued op", 32'(seen), 32'd0);
        check("bp result kept", result, 32'd5);

        // Flush at cycle 3 of SLL 1<<10
        run_op("pre_flush", 4'd9, 32'h0000_00FF, 32'h0000_00F0, 32'h0000_00F0, 1'b0, 1);
        wait_ready("flush_shift");
        alu_control = 4'd2; a = 32'd1; b = 32'd10; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush out_valid never", 32'(seen), 32'd0);
        check("flush result kept", result, 32'h0000_00F0);
        run_op("post_flush_add", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        // Flush in DONE with out_ready high discards the result.
        wait_ready("flush_done");
        alu_control = 4'd0; a = 32'd7; b = 32'd8; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("fd out_valid before", 32'(out_valid), 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 begin flush = 1'b0; out_ready = 1'b0; end
        check("fd out_valid", 32'(out_valid), 32'd0);
        check("fd in_ready", 32'(in_ready), 32'd1);
        check("fd result kept", result, 32'd15);

        // Flush coincident with accept drops the operation.
        @(negedge clk);
        alu_control = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin in_valid = 1'b0; flush = 1'b0; end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen++;
        end
        check("flush+accept dropped", 32'(seen), 32'd0);
        check("flush+accept result", result, 32'd15);

        // Asynchronous reset between edges in the middle of a long shift
        wait_ready("arst");
        alu_control = 4'd7; a = 32'h8000_0000; b = 32'd31; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst in_ready", 32'(in_ready), 32'd1);
        check("arst out_valid", 32'(out_valid), 32'd0);
        check("arst result", result, 32'd0);
        check("arst zero", 32'(zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (35) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("arst no partial", 32'(seen), 32'd0);
        run_op("post_rst_undef", 4'hC, 32'd3, 32'd4, 32'd0, 1'b1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
